// File: rtl/tick_sched_pkg.sv
// tick_sched_pkg: shared types and constants for the tick_sched timebase.
//   - default sizes for the channel count, counter width and channel index width
//   - configuration FSM state encoding
//   - channel configuration record
//   - named periods for the standard consumers at a 100 MHz system clock
package tick_sched_pkg;

  localparam int NCH_DEF = 4;
  localparam int CW_DEF  = 32;
  localparam int CHW_DEF = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOAD = 1'b1
  } cfg_state_e;

  typedef struct packed {
    logic [CW_DEF-1:0] period;
    logic              oneshot;
    logic              en;
  } chan_cfg_t;

  // Display scan, one-second and two-second timebases.
  localparam logic [CW_DEF-1:0] P_DISP = 32'd1_048_576;
  localparam logic [CW_DEF-1:0] P_SEC  = 32'd100_000_000;
  localparam logic [CW_DEF-1:0] P_2SEC = 32'd200_000_000;

endpackage

// File: rtl/tick_sched_chan.sv
// tick_chan: one tick channel of the tick_sched timebase.
// Counts clk cycles and emits a one-cycle tick every period cycles; a one-shot
// channel disables itself on its first tick and raises a sticky done flag.
// Optional square-wave output when TICK_SCHED_LVL_EN is defined.
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   load_i          write the cfg_* values into this channel (restarts it)
//   cfg_period_i    tick period in clk cycles (0 = inert)
//   cfg_oneshot_i   stop after the first tick
//   cfg_en_i        channel enable
//   sync_i          zero the counter (phase align)
//   tick_o          one-cycle tick pulse
//   done_o          one-shot channel has fired (sticky until next load)
//   lvl_o           toggles on every tick (0 when TICK_SCHED_LVL_EN undefined)
module tick_chan
  import tick_sched_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [CW-1:0] cfg_period_i,
  input  logic          cfg_oneshot_i,
  input  logic          cfg_en_i,
  input  logic          sync_i,
  output logic          tick_o,
  output logic          done_o,
  output logic          lvl_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] period_q;
  logic          oneshot_q;
  logic          en_q;
  logic          done_q;
  logic          active;
  logic          at_end;

  // A zero period keeps the channel inert, which also makes period_q - 1
  // (all ones) harmless: at_end is never used while period_q is 0.
  assign active = en_q && (period_q != '0);
  assign at_end = (cnt_q == (period_q - CW'(1)));
  // A load to this channel wins over a tick landing in the same cycle.
  assign tick_o = active && at_end && !load_i;
  assign done_o = done_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i || sync_i || tick_o) begin
      cnt_d = '0;
    end else if (active) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      period_q  <= '0;
      oneshot_q <= 1'b0;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (load_i) begin
        period_q  <= cfg_period_i;
        oneshot_q <= cfg_oneshot_i;
        en_q      <= cfg_en_i;
        done_q    <= 1'b0;
      end else if (tick_o && oneshot_q) begin
        en_q   <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

`ifdef TICK_SCHED_LVL_EN
  logic lvl_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_q <= 1'b0;
    end else if (load_i) begin
      lvl_q <= 1'b0;
    end else if (tick_o) begin
      lvl_q <= ~lvl_q;
    end
  end

  assign lvl_o = lvl_q;
`else
  assign lvl_o = 1'b0;
`endif

endmodule

// File: rtl/tick_sched.sv
// tick_sched: programmable timebase with NCH independent tick channels.
// A two-state config FSM (IDLE/LOAD) accepts one write per two cycles over a
// valid/ready port, holds it for one cycle, then loads the target channel.
// Writes to a channel index >= NCH complete the handshake but change nothing.
// Optional feature macro: TICK_SCHED_LVL_EN (square-wave tick_lvl outputs).
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   cfg_valid     configuration write request
//   cfg_ready     write can be accepted this cycle (high in IDLE)
//   cfg_ch        target channel index
//   cfg_period    tick period in clk cycles (0 = inert)
//   cfg_oneshot   1 = stop after first tick
//   cfg_en        channel enable
//   sync          zero all channel counters
//   tick          one-cycle tick per channel
//   done          sticky one-shot fired flag per channel
//   tick_lvl      per-channel toggle on tick (0 when feature disabled)
module tick_sched
  import tick_sched_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int CW  = CW_DEF,
  parameter int CHW = CHW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_period,
  input  logic           cfg_oneshot,
  input  logic           cfg_en,
  input  logic           sync,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] done,
  output logic [NCH-1:0] tick_lvl
);

  cfg_state_e     state_q, state_d;
  logic           accept;
  logic [CHW-1:0] hold_ch_q;
  logic [CW-1:0]  hold_period_q;
  logic           hold_oneshot_q;
  logic           hold_en_q;

  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          accept  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Holding registers are only consumed in LOAD, which always follows a
  // capture, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_ch_q      <= cfg_ch;
      hold_period_q  <= cfg_period;
      hold_oneshot_q <= cfg_oneshot;
      hold_en_q      <= cfg_en;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    logic load;

    // Out-of-range indices never match any generated channel.
    assign load = (state_q == LOAD) && (hold_ch_q == CHW'(g));

    tick_chan #(
      .CW(CW)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .load_i       (load),
      .cfg_period_i (hold_period_q),
      .cfg_oneshot_i(hold_oneshot_q),
      .cfg_en_i     (hold_en_q),
      .sync_i       (sync),
      .tick_o       (tick[g]),
      .done_o       (done[g]),
      .lvl_o        (tick_lvl[g])
    );
  end

endmodule
